bus_io_port: RTL and testbench

- Memory-mapped I/O responder on the simpcpu data bus, at the target end of the CPU's addrout/dataout/datawrite/hold interface; sits beside the RAM.
- Decodes a 4-word window at BASE and buffers CPU writes into a TX FIFO, which is drained downstream over valid/ready.
- Latches one inbound RX word for the CPU to read.
- Asserts hold to stall the CPU when a TX write arrives while the FIFO is full.

---
 rtl/bus_io_pkg.sv | 18 +
 rtl/bus_io_port_if.sv | 29 ++
 rtl/bus_io_port_sync_fifo.sv | 53 +++++
 rtl/bus_io_port.sv | 103 ++++++++++
 tb/tb_bus_io_port.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bus_io_pkg.sv
// Shared constants for the bus_io_port memory-mapped I/O responder:
// register offsets, STATUS bit positions and the data-bus word type.
package bus_io_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_RXDATA = 2'd2;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXAVAIL = 2;
  localparam int ST_CNT_LSB = 8;

endpackage

// File: rtl/bus_io_port_if.sv
// CPU data-bus, TX stream and RX stream signals of bus_io_port.
// slave = the port itself, master = CPU plus downstream/upstream peers.
interface bus_io_if;
  import bus_io_pkg::*;

  word_t addr;
  word_t din;
  logic  wr;
  word_t dout;
  logic  sel;
  logic  hold;
  word_t tx_data;
  logic  tx_valid;
  logic  tx_ready;
  word_t rx_data;
  logic  rx_valid;
  logic  rx_ready;

  modport slave (
    input  addr, din, wr, tx_ready, rx_data, rx_valid,
    output dout, sel, hold, tx_data, tx_valid, rx_ready
  );

  modport master (
    output addr, din, wr, tx_ready, rx_data, rx_valid,
    input  dout, sel, hold, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/bus_io_port_sync_fifo.sv
// Single-clock FIFO with a combinational head word (rdata valid whenever !empty).
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/bus_io_port.sv
// Memory-mapped I/O responder: 4-word window at BASE with TX FIFO, RX latch,
// STATUS register, 1-cycle registered read path and CPU hold on TX overflow.
module bus_io_port
  import bus_io_pkg::*;
#(
  parameter logic [15:0] BASE  = 16'h1000,
  parameter int          DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  bus_io_if.slave  bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             w_hit;
  logic [1:0]       w_ofs;
  logic             w_tx_wr;
  logic             w_push;
  logic             w_pop;
  logic             w_ack;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  word_t            w_status;
  word_t            w_rd_next;
  word_t            r_dout;
  logic             r_sel;
  word_t            r_rx_data;
  logic             r_rx_avail;

  assign w_hit   = (bus.addr[15:2] == BASE[15:2]);
  assign w_ofs   = bus.addr[1:0];
  assign w_tx_wr = bus.wr && w_hit && (w_ofs == OFS_TXDATA);
  assign w_push  = w_tx_wr && !w_full;
  assign w_pop   = !w_empty && bus.tx_ready;
  assign w_ack   = bus.wr && w_hit && (w_ofs == OFS_RXDATA);

  // Registered full flag: a pop in the same cycle does not release the stall.
  assign bus.hold     = w_tx_wr && w_full;
  assign bus.tx_valid = !w_empty;
  assign bus.rx_ready = !r_rx_avail;
  assign bus.dout     = r_dout;
  assign bus.sel      = r_sel;

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (w_push),
    .wdata (bus.din),
    .pop   (w_pop),
    .rdata (bus.tx_data),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_comb begin
    w_status                         = '0;
    w_status[ST_TXFULL]              = w_full;
    w_status[ST_TXEMPTY]             = w_empty;
    w_status[ST_RXAVAIL]             = r_rx_avail;
    w_status[ST_CNT_LSB +: CNT_W]    = w_count;
  end

  always_comb begin
    w_rd_next = '0;
    if (w_hit) begin
      case (w_ofs)
        OFS_STATUS: w_rd_next = w_status;
        OFS_RXDATA: w_rd_next = r_rx_data;
        default:    w_rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
      r_sel  <= 1'b0;
    end else begin
      r_dout <= w_rd_next;
      r_sel  <= w_hit;
    end
  end

  // Capture only happens while empty, so an ack on an empty latch cannot lose a word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_data  <= '0;
      r_rx_avail <= 1'b0;
    end else if (bus.rx_valid && !r_rx_avail) begin
      r_rx_data  <= bus.rx_data;
      r_rx_avail <= 1'b1;
    end else if (w_ack) begin
      r_rx_avail <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bus_io_port.sv
// Directed bench for bus_io_port: TX words go through a scoreboard queue that a
// negedge monitor drains and compares; register reads are checked 1 cycle later.
module tb_bus_io_port;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  logic [15:0] exp_q[$];
  logic [15:0] last_drained;

  bus_io_if bus ();

  bus_io_port #(
    .BASE  (16'h1000),
    .DEPTH (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drain monitor: a word at the head with tx_ready high leaves at the next posedge.
  always @(negedge clk) begin
    if (rst && bus.tx_valid && bus.tx_ready) begin
      if (exp_q.size() == 0) begin
        check("tx_unexpected_word", bus.tx_data, 16'hxxxx);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("tx_data", bus.tx_data, e);
        last_drained = bus.tx_data;
        $display("drain data=%h", bus.tx_data);
      end
    end
  end

  task automatic rd(input logic [15:0] a, input logic [15:0] exp_dout, input logic exp_sel);
    bus.addr = a;
    bus.wr   = 1'b0;
    @(posedge clk); #1;
    $display("read  addr=%h dout=%h sel=%0d", a, bus.dout, bus.sel);
    check("rd_dout", bus.dout, exp_dout);
    check("rd_sel", {15'd0, bus.sel}, {15'd0, exp_sel});
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.wr   = 1'b1;
    @(negedge clk);
    check("wr_hold", {15'd0, bus.hold}, 16'd0);
    if (a == 16'h1000) exp_q.push_back(d);
    $display("write addr=%h data=%h", a, d);
    @(posedge clk); #1;
    bus.wr = 1'b0;
  endtask

  task automatic wait_drain();
    int cyc;
    cyc = 0;
    while (bus.tx_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("drain_timeout", {15'd0, bus.tx_valid}, 16'd0);
    check("drain_queue_left", 16'(exp_q.size()), 16'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    last_drained = '0;
    rst = 1'b0;
    bus.addr = '0; bus.din = '0; bus.wr = 1'b0;
    bus.tx_ready = 1'b0; bus.rx_data = '0; bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Push / drain
    wr(16'h1000, 16'hA5A5);
    wr(16'h1000, 16'h1234);
    rd(16'h1001, 16'h0200, 1'b1);
    bus.tx_ready = 1'b1;
    wait_drain();
    bus.tx_ready = 1'b0;

    // Mid-run reset with data buffered and an RX word latched
    wr(16'h1000, 16'h1111);
    bus.rx_data = 16'h7777; bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    check("rst_rx_ready", {15'd0, bus.rx_ready}, 16'd1);
    check("rst_hold", {15'd0, bus.hold}, 16'd0);
    check("rst_dout", bus.dout, 16'h0000);
    check("rst_sel", {15'd0, bus.sel}, 16'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    rd(16'h1001, 16'h0002, 1'b1);
    check("post_rst_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    check("post_rst_rx_ready", {15'd0, bus.rx_ready}, 16'd1);

    // Full stall
    for (int i = 0; i < 8; i++) wr(16'h1000, 16'h0100 + 16'(i));
    rd(16'h1001, 16'h0801, 1'b1);
    bus.addr = 16'h1000; bus.din = 16'hBEEF; bus.wr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("hold_while_full", {15'd0, bus.hold}, 16'd1);
      @(posedge clk); #1;
    end
    bus.tx_ready = 1'b1;
    @(negedge clk);
    check("hold_same_cycle_pop", {15'd0, bus.hold}, 16'd1);
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    @(negedge clk);
    check("hold_released", {15'd0, bus.hold}, 16'd0);
    exp_q.push_back(16'hBEEF);
    @(posedge clk); #1;
    bus.wr = 1'b0;
    rd(16'h1001, 16'h0801, 1'b1);
    bus.tx_ready = 1'b1;
    wait_drain();
    check("last_drained", last_drained, 16'hBEEF);
    bus.tx_ready = 1'b0;

    // RX latch
    bus.rx_data = 16'h5A5A; bus.rx_valid = 1'b1;
    @(negedge clk);
    check("rx_ready_before", {15'd0, bus.rx_ready}, 16'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    check("rx_ready_after", {15'd0, bus.rx_ready}, 16'd0);
    rd(16'h1002, 16'h5A5A, 1'b1);
    rd(16'h1002, 16'h5A5A, 1'b1);
    rd(16'h1001, 16'h0006, 1'b1);
    wr(16'h1002, 16'h0000);
    check("rx_ready_acked", {15'd0, bus.rx_ready}, 16'd1);
    rd(16'h1001, 16'h0002, 1'b1);

    // Decode
    rd(16'h0FFF, 16'h0000, 1'b0);
    rd(16'h1004, 16'h0000, 1'b0);
    rd(16'h1003, 16'h0000, 1'b1);
    rd(16'h1000, 16'h0000, 1'b1);
    wr(16'h1001, 16'hFFFF);
    wr(16'h1003, 16'hFFFF);
    check("decode_tx_valid", {15'd0, bus.tx_valid}, 16'd0);
    check("decode_rx_ready", {15'd0, bus.rx_ready}, 16'd1);
    rd(16'h1001, 16'h0002, 1'b1);

    // Pointer wrap with concurrent push/pop
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.addr = 16'h1000; bus.din = 16'hC000 + 16'(i); bus.wr = 1'b1;
      @(negedge clk);
      check("wrap_hold", {15'd0, bus.hold}, 16'd0);
      check("wrap_count_le1", {15'd0, (dut.w_count <= 4'd1)}, 16'd1);
      exp_q.push_back(16'hC000 + 16'(i));
      @(posedge clk); #1;
    end
    bus.wr = 1'b0;
    wait_drain();
    check("wrap_last", last_drained, 16'hC013);
    bus.tx_ready = 1'b0;
    rd(16'h1001, 16'h0002, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
